nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
Sequencer that adds two NIBBLES*4-bit operands, one nibble per cycle, through a single shared 4-bit ripple adder (the team's fulladd slice, instantiated outside this block). It latches the operands and carry-in on a start request and drives the adder's a/b/c_in nibble by nibble. It captures the adder's sum/c_out each cycle and chains the carry from nibble to nibble. It presents the full-width result with a one-cycle done pulse. Wide-operand arithmetic uses this block instead of a full-width adder.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled in IDLE or DONE only
op_a  input  W  operand A, sampled with start
op_b  input  W  operand B, sampled with start
c_in  input  1  carry-in, sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; high exactly in DONE
result  output  W  final sum; held until the next completion
c_out  output  1  final carry-out; held with result
fa_a  output  4  nibble A to shared adder
fa_b  output  4  nibble B to shared adder
fa_c_in  output  1  chained carry to shared adder
fa_sum  input  4  adder sum (combinational from fa_a/fa_b/fa_c_in)
fa_c_out  input  1  adder carry-out

Behaviour:
- States: IDLE, RUN, DONE. Register state, idx (ceil(log2(NIBBLES)) bits, min 1), carry, a_reg, b_reg, work.
- Reset (rst_n low, async): state=IDLE, idx=0, carry=0, a_reg=b_reg=work=0, result=0, c_out=0. Outputs: busy=0, done=0, fa_*=0.
- IDLE/DONE + start=1 at an edge: a_reg<=op_a, b_reg<=op_b, carry<=c_in, idx<=0, state<=RUN. Without start: IDLE stays IDLE; DONE goes to IDLE.
- RUN, combinational drive: fa_a=a_reg[4*idx+:4], fa_b=b_reg[4*idx+:4], fa_c_in=carry.
- RUN, at each edge: work[4*idx+:4]<=fa_sum, carry<=fa_c_out.
  - If idx<NIBBLES-1: idx<=idx+1.
  - Else: result<={fa_sum, work lower bits}, c_out<=fa_c_out, state<=DONE.
- fa_a/fa_b/fa_c_in are 0 outside RUN.
- Latency: start accepted at edge E. RUN occupies cycles E..E+NIBBLES-1. done=1 in the cycle after edge E+NIBBLES. result/c_out are valid in that same cycle.
- Throughput: one operation per NIBBLES+1 cycles when start is held high (DONE accepts the next start).
- start in RUN: ignored, no queueing. op_a/op_b/c_in may change freely after acceptance.
- result/c_out change only on completion. A new operation does not disturb them until its own DONE.
- Arithmetic: {c_out,result} = op_a + op_b + c_in, modulo 2^(W+1). Wrap is exact: 0xFFFF+0x0000+1 gives 0x0000, c_out=1.
- Reset asserted mid-RUN: operation aborted, no done pulse, result/c_out cleared to 0.
- NIBBLES=1: a single RUN cycle, then DONE.

Test Plan:
- Reset, start with op_a=0x0000, op_b=0x0000, c_in=0 at edge 0 -> busy high for cycles 0-3; done=1 in cycle 4 only; result=0x0000, c_out=0; fa_* 0 in cycle 4.
- op_a=0xFFFF, op_b=0x0001, c_in=0 -> fa_c_in sequence 0,1,1,1; result=0x0000, c_out=1.
- op_a=0x1234, op_b=0x4321, c_in=1 -> fa_a sequence 4,3,2,1; result=0x5556, c_out=0. Then pulse start again during RUN -> ignored, exactly one done.
- start held high continuously with (0x8000+0x8000, c_in 0) then (0x0001+0x0002, c_in 0) -> done every 5 cycles. Results in order: 0x0000/c_out=1, then 0x0003/c_out=0. result is held between the two done pulses.
- Start 0xAAAA+0x5555, c_in=1, then drop rst_n for 1 cycle during the 2nd RUN cycle -> no done; result=0, c_out=0, state IDLE. A fresh start afterwards gives 0x0000, c_out=1.
- NIBBLES=1: 0xF+0x1, c_in=1 -> done in the 2nd cycle after the start edge, result=0x1, c_out=1.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_if.sv
// Start/operand/result bundle and shared-adder port group for nibble_serial_add_ctrl.
// Handshake: start is sampled only when the sequencer is not busy (IDLE or DONE);
// done pulses for exactly one cycle with result/c_out valid; there is no backpressure.
interface nibble_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic [3:0]   fa_a;
    logic [3:0]   fa_b;
    logic         fa_c_in;
    logic [3:0]   fa_sum;
    logic         fa_c_out;

    modport slave (
        input  start, op_a, op_b, c_in, fa_sum, fa_c_out,
        output busy, done, result, c_out, fa_a, fa_b, fa_c_in
    );

    modport master (
        output start, op_a, op_b, c_in, fa_sum, fa_c_out,
        input  busy, done, result, c_out, fa_a, fa_b, fa_c_in
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Wide-operand adder sequencer: feeds one nibble per cycle through an external
// 4-bit adder, chaining the carry, and publishes the full sum with a done pulse.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    nibble_serial_add_ctrl_if.slave   bus,
    output logic [1:0]                o_dbg_state
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_work;
    logic [W-1:0]    r_result;
    logic            r_c_out;
    logic [W-1:0]    w_final;

    // Final result: top nibble comes straight from the adder in the last RUN cycle.
    always_comb begin
        w_final          = r_work;
        w_final[W-1 -: 4] = bus.fa_sum;
    end

    always_comb begin
        bus.fa_a    = 4'd0;
        bus.fa_b    = 4'd0;
        bus.fa_c_in = 1'b0;
        if (r_state == ST_RUN) begin
            bus.fa_a    = r_a[4*r_idx +: 4];
            bus.fa_b    = r_b[4*r_idx +: 4];
            bus.fa_c_in = r_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_work   <= '0;
            r_result <= '0;
            r_c_out  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_a     <= bus.op_a;
                        r_b     <= bus.op_b;
                        r_carry <= bus.c_in;
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_work[4*r_idx +: 4] <= bus.fa_sum;
                    r_carry              <= bus.fa_c_out;
                    if (r_idx != LAST) begin
                        r_idx <= r_idx + IW'(1);
                    end else begin
                        r_result <= w_final;
                        r_c_out  <= bus.fa_c_out;
                        r_state  <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = (r_state == ST_RUN);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.result  = r_result;
    assign bus.c_out   = r_c_out;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (NIBBLES=4 and NIBBLES=1) with an
// expected-result queue checked on every done pulse.
module tb_nibble_serial_add_ctrl;
    logic clk;
    logic rst_n;
    logic [1:0] st0;
    logic [1:0] st1;

    nibble_serial_add_ctrl_if #(.NIBBLES(4)) bus ();
    nibble_serial_add_ctrl_if #(.NIBBLES(1)) bus1 ();

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .o_dbg_state(st0)
    );
    nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .o_dbg_state(st1)
    );

    // Behavioural model of the shared 4-bit adder slice.
    assign {bus.fa_c_out, bus.fa_sum}   = 5'(bus.fa_a) + 5'(bus.fa_b) + 5'(bus.fa_c_in);
    assign {bus1.fa_c_out, bus1.fa_sum} = 5'(bus1.fa_a) + 5'(bus1.fa_b) + 5'(bus1.fa_c_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [16:0] exp_q[$];
    logic [16:0] last_res;
    logic [3:0]  seq_a[4];
    logic        seq_c[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL spurious_done observed=%0h expected=none", {bus.c_out, bus.result});
            end else begin
                chk("result", 32'({bus.c_out, bus.result}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci, input bit glitch);
        logic [16:0] e;
        e = 17'(a) + 17'(b) + 17'(ci);
        bus.op_a = a; bus.op_b = b; bus.c_in = ci; bus.start = 1'b1;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) begin
                bus.start = 1'b0;
                bus.op_a = ~a; bus.op_b = ~b; bus.c_in = ~ci;
            end
            if (glitch && k == 1) bus.start = 1'b1;
            if (glitch && k == 2) bus.start = 1'b0;
            seq_a[k] = bus.fa_a;
            seq_c[k] = bus.fa_c_in;
            chk("busy_run", 32'(bus.busy), 32'd1);
            chk("done_in_run", 32'(bus.done), 32'd0);
            chk("result_held", 32'({bus.c_out, bus.result}), 32'(last_res));
        end
        step();
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("busy_done", 32'(bus.busy), 32'd0);
        chk("fa_zero_done", 32'({bus.fa_a, bus.fa_b, bus.fa_c_in}), 32'd0);
        last_res = e;
    endtask

    initial begin
        int d0;
        logic [15:0] ra, rb;
        logic        rc;
        rst_n = 1'b0;
        last_res = '0;
        bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.c_in = 1'b0;
        bus1.start = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.c_in = 1'b0;
        step();
        chk("rst_state", 32'(st0), 32'd0);
        chk("rst_busy_done", 32'({bus.busy, bus.done}), 32'd0);
        chk("rst_result", 32'({bus.c_out, bus.result}), 32'd0);
        chk("rst_fa", 32'({bus.fa_a, bus.fa_b, bus.fa_c_in}), 32'd0);
        rst_n = 1'b1;
        step();

        // zero operands, basic latency
        do_op(16'h0000, 16'h0000, 1'b0, 1'b0);
        step();
        chk("idle_after_done", 32'(st0), 32'd0);
        chk("done_one_cycle", 32'(bus.done), 32'd0);

        // full carry ripple
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        chk("fa_c_in_seq", 32'({seq_c[0], seq_c[1], seq_c[2], seq_c[3]}), 32'b0111);
        step();

        // nibble order, start during RUN ignored
        d0 = done_cnt;
        do_op(16'h1234, 16'h4321, 1'b1, 1'b1);
        chk("fa_a_seq", 32'({seq_a[0], seq_a[1], seq_a[2], seq_a[3]}), 32'h4321);
        step(); step(); step();
        chk("single_done", 32'(done_cnt - d0), 32'd1);
        chk("idle_after_glitch", 32'(st0), 32'd0);

        // start held high: back-to-back operations every 5 cycles
        bus.op_a = 16'h8000; bus.op_b = 16'h8000; bus.c_in = 1'b0; bus.start = 1'b1;
        exp_q.push_back(17'h10000);
        step();
        bus.op_a = 16'h0001; bus.op_b = 16'h0002;
        exp_q.push_back(17'h00003);
        for (int c = 1; c < 10; c++) begin
            if (c != 0) step();
            chk("hold_done", 32'(bus.done), (c == 4 || c == 9) ? 32'd1 : 32'd0);
            if (c > 4 && c < 9) chk("hold_between", 32'({bus.c_out, bus.result}), 32'h10000);
        end
        bus.start = 1'b0;
        last_res = 17'h00003;
        step();
        chk("hold_end_idle", 32'(st0), 32'd0);

        // reset during the second RUN cycle
        bus.op_a = 16'hAAAA; bus.op_b = 16'h5555; bus.c_in = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_state", 32'(st0), 32'd0);
        chk("abort_result", 32'({bus.c_out, bus.result}), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        step();
        rst_n = 1'b1;
        last_res = '0;
        d0 = done_cnt;
        step(); step(); step(); step(); step();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        do_op(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        step();
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        step();

        // random operands
        for (int r = 0; r < 4; r++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            do_op(ra, rb, rc, 1'b0);
            if (r[0]) step();
        end
        step();

        // single-nibble instance
        bus1.op_a = 4'hF; bus1.op_b = 4'h1; bus1.c_in = 1'b1; bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        chk("n1_busy", 32'({bus1.busy, bus1.done}), 32'b10);
        chk("n1_fa", 32'({bus1.fa_a, bus1.fa_b, bus1.fa_c_in}), 32'b1111_0001_1);
        step();
        chk("n1_done", 32'({bus1.busy, bus1.done}), 32'b01);
        chk("n1_result", 32'({bus1.c_out, bus1.result}), 32'h11);
        step();
        chk("n1_idle", 32'(st1), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
